// File: rtl/z_scan_pkg.sv
// z_scan_pkg: shared types and constants for the Z-order scan generator.
package z_scan_pkg;
  localparam int Z_BLK_LOG2 = 3;
  localparam int N = 1 << Z_BLK_LOG2;
  localparam int LAST_CNT = N * N - 1;
  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_e;
  function automatic int last_cnt(input int b);
    return (1 << (2 * b)) - 1;
  endfunction
endpackage

// File: rtl/z_scan_deint.sv
// z_scan_deint: de-interleaves a Morton counter (x in even bits, y in odd) into a raster index {y,x}.
module z_scan_deint
  import z_scan_pkg::*;
#(parameter int BLK_LOG2 = Z_BLK_LOG2) (
  input  logic [2*BLK_LOG2-1:0] cnt_i,
  output logic [2*BLK_LOG2-1:0] zid_o
);
  for (genvar i = 0; i < BLK_LOG2; i++) begin : g_bit
    assign zid_o[i]            = cnt_i[2*i];
    assign zid_o[BLK_LOG2 + i] = cnt_i[2*i+1];
  end
endmodule

// File: rtl/z_scan.sv
// z_scan: Z-order scan address generator; sob launches N*N raster indices, one per cycle.
// Optional end-of-block flag on the last position when Z_SCAN_EOB_EN is defined.
module z_scan
  import z_scan_pkg::*;
#(parameter int BLK_LOG2 = Z_BLK_LOG2) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sob,
  output logic [2*BLK_LOG2-1:0] zid,
  output logic                  zid_vld
`ifdef Z_SCAN_EOB_EN
  ,
  output logic                  eob
`endif
);
  localparam int ZID_W = 2 * BLK_LOG2;
  localparam logic [ZID_W-1:0] LAST = ZID_W'(last_cnt(BLK_LOG2));
  state_e state_q, state_d;
  logic [ZID_W-1:0] cnt_q, cnt_d, zid_q, zid_d;
  logic eob_q, eob_d;
  // cnt_q tracks the Z position currently on the outputs; a sob always restarts at 0
  always_comb begin
    state_d = (sob || (state_q == SCAN && cnt_q != LAST)) ? SCAN : IDLE;
    cnt_d   = (state_d == SCAN && !sob) ? cnt_q + 1'b1 : '0;
    eob_d   = (state_d == SCAN) && (cnt_d == LAST);
  end
  z_scan_deint #(.BLK_LOG2(BLK_LOG2)) u_deint (.cnt_i(cnt_d), .zid_o(zid_d));
  // rst_n is active-high despite its name
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      zid_q   <= '0;
      eob_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      zid_q   <= zid_d;
      eob_q   <= eob_d;
    end
  end
  assign zid     = zid_q;
  assign zid_vld = (state_q == SCAN);
`ifdef Z_SCAN_EOB_EN
  assign eob = eob_q;
`else
  logic unused_eob;
  assign unused_eob = eob_q;
`endif
endmodule

// File: tb/tb_z_scan.sv
// tb_z_scan: self-checking bench for z_scan against a quadrant-recursion reference model.
module tb_z_scan;
  localparam int B = 3;
  localparam int NN = 1 << B;
  localparam int TOT = NN * NN;
  logic clk = 1'b0, rst_n = 1'b1, sob = 1'b0;
  logic [2*B-1:0] zid;
  logic zid_vld;
  logic eob;
  int n_chk = 0, n_fail = 0;
  int pos = -1;
  typedef struct {bit s; bit vld; int z;} vec_t;
  vec_t tbl[20];
  int first_seq[20] = '{0,1,8,9,2,3,10,11,16,17,24,25,18,19,26,27,4,5,12,13};
  int seen[TOT];
  int nv;
  bit hit;

  always #5 clk = ~clk;

  z_scan #(.BLK_LOG2(B)) dut (
    .clk(clk), .rst_n(rst_n), .sob(sob), .zid(zid), .zid_vld(zid_vld)
`ifdef Z_SCAN_EOB_EN
    , .eob(eob)
`endif
  );
`ifndef Z_SCAN_EOB_EN
  assign eob = 1'b0;
`endif

  function automatic int zmap(input int p);
    int x = 0, y = 0, span = NN, q;
    for (int l = 0; l < B; l++) begin
      span = span / 2;
      q = (p >> (2 * (B - 1 - l))) % 4;
      x += (q % 2) * span;
      y += (q / 2) * span;
    end
    return y * NN + x;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("vld", int'(zid_vld), int'(pos >= 0));
    chk("zid", int'(zid), pos >= 0 ? zmap(pos) : 0);
`ifdef Z_SCAN_EOB_EN
    chk("eob", int'(eob), int'(pos == TOT - 1));
`endif
  endtask

  task automatic cyc(input bit s);
    sob = s;
    @(posedge clk);
    if (s) pos = 0;
    else if (pos >= 0) pos = (pos == TOT - 1) ? -1 : pos + 1;
    @(negedge clk);
    check_model();
  endtask

  initial begin
    for (int i = 0; i < 20; i++) tbl[i] = '{s: (i == 0), vld: 1'b1, z: first_seq[i]};
    #2;
    chk("rst_vld", int'(zid_vld), 0);
    chk("rst_zid", int'(zid), 0);
    chk("rst_eob", int'(eob), 0);
    @(negedge clk);
    rst_n = 1'b0;
    cyc(0);
    cyc(0);
    // first burst: table-driven prefix, then coverage of all positions
    for (int i = 0; i < TOT; i++) seen[i] = 0;
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(tbl[i].s);
      chk("tbl_vld", int'(zid_vld), int'(tbl[i].vld));
      chk("tbl_zid", int'(zid), tbl[i].z);
      if (zid_vld) begin seen[zid]++; nv++; end
    end
    for (int i = 0; i < 100 && zid_vld; i++) begin
      cyc(0);
      if (zid_vld) begin seen[zid]++; nv++; end
    end
    chk("burst_len", nv, TOT);
    chk("idle_zid", int'(zid), 0);
    chk("idle_vld", int'(zid_vld), 0);
    for (int i = 0; i < TOT; i++) if (seen[i] != 1) chk("coverage", seen[i], 1);
    n_chk++;
    // restart after 10 valid cycles
    nv = 0;
    cyc(1); nv++;
    for (int i = 0; i < 9; i++) begin cyc(0); nv += int'(zid_vld); end
    cyc(1); nv += int'(zid_vld);
    chk("restart_zid", int'(zid), 0);
    for (int i = 0; i < 200 && zid_vld; i++) begin cyc(0); nv += int'(zid_vld); end
    chk("restart_total", nv, 74);
    // sob held 3 cycles
    cyc(1); chk("hold0", int'(zid), 0);
    cyc(1); chk("hold1", int'(zid), 0);
    cyc(1); chk("hold2", int'(zid), 0);
    cyc(0); chk("hold3", int'(zid), 1);
    cyc(0); chk("hold4", int'(zid), 8);
    cyc(0); chk("hold5", int'(zid), 9);
    for (int i = 0; i < 100 && zid_vld; i++) cyc(0);
    // restart coincident with the last position
    cyc(1);
    for (int i = 0; i < TOT - 1; i++) cyc(0);
    chk("last_zid", int'(zid), TOT - 1);
    cyc(1);
    chk("last_restart_zid", int'(zid), 0);
    chk("last_restart_vld", int'(zid_vld), 1);
    // asynchronous reset mid-burst at zid 27
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      cyc(0);
      hit = (pos >= 0) && (zmap(pos) == 27);
    end
    chk("reach27", int'(hit), 1);
    #2 rst_n = 1'b1;
    #1;
    chk("async_vld", int'(zid_vld), 0);
    chk("async_zid", int'(zid), 0);
    pos = -1;
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) cyc(0);
    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) cyc($urandom_range(0, 79) == 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
